sram_pkt_writer: RTL and testbench

//  Write-side controller in front of the dual-port packet SRAM (32b x 16K, two 16b halves). Accepts

---
 rtl/eth_sw_pkg.sv | 17 +
 rtl/sram_bwen_expand.sv | 16 +
 rtl/sram_pkt_writer.sv | 204 ++++++++++++++++++++
 tb/tb_sram_pkt_writer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sw_pkg.sv
// Shared definitions for the switch packet-buffer write path: SRAM geometry, frame limit and
// writer FSM state encoding.
package eth_sw_pkg;

    localparam int unsigned SramBits      = 32;
    localparam int unsigned SramWordDepth = 16384;
    localparam int unsigned SramAddWidth  = 14;
    localparam int unsigned MaxFrameWords = 388;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDrop,
        StDesc
    } pkt_wr_state_e;

endpackage

// File: rtl/sram_bwen_expand.sv
// Expands a per-byte keep mask into the SRAM's active-low per-bit write-enable vector.
module sram_bwen_expand #(
    parameter int unsigned KeepWidth = 4
) (
    input  logic [KeepWidth-1:0]   keep_i,
    output logic [KeepWidth*8-1:0] bwen_o
);

    always_comb begin
        bwen_o = '1;
        for (int i = 0; i < int'(KeepWidth); i++) begin
            bwen_o[i*8 +: 8] = {8{~keep_i[i]}};
        end
    end

endmodule

// File: rtl/sram_pkt_writer.sv
// Ingress frame writer into the circular packet SRAM with per-frame descriptor commit.
// Optional frame/drop statistics counters are enabled by defining PKT_WR_STATS_EN.
module sram_pkt_writer
    import eth_sw_pkg::*;
#(
    parameter int unsigned Bits       = SramBits,
    parameter int unsigned Word_Depth = SramWordDepth,
    parameter int unsigned Add_Width  = SramAddWidth,
    parameter int unsigned Wen_Width  = SramBits,
    parameter int unsigned MAX_WORDS  = MaxFrameWords
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic                 iSop,
    input  logic                 iEop,
    input  logic [Bits/8-1:0]    iKeep,
    input  logic [Bits-1:0]      iData,
    output logic                 oCEnA,
    output logic                 oWEnA,
    output logic [Wen_Width-1:0] oBWEnA,
    output logic [Add_Width-1:0] oAddrA,
    output logic [Bits-1:0]      oWDataA,
    input  logic [Add_Width:0]   iRdPtr,
    output logic [Add_Width:0]   oWrPtr,
    output logic                 oDescValid,
    input  logic                 iDescReady,
    output logic [Add_Width-1:0] oDescAddr,
    output logic [Add_Width:0]   oDescLen,
    output logic [Bits/8-1:0]    oDescLastBe
`ifdef PKT_WR_STATS_EN
    ,
    output logic [31:0]          oFrmCnt,
    output logic [31:0]          oDropCnt
`endif
);

    localparam int unsigned PtrW  = Add_Width + 1;
    localparam int unsigned KeepW = Bits / 8;

    pkt_wr_state_e state_q, state_d;

    logic                 ready_q, ready_d;
    logic [PtrW-1:0]      cur_ptr_q, cur_ptr_d, wr_ptr_q, wr_ptr_d, len_q, len_d;
    logic                 cen_q, cen_d, wen_q, wen_d;
    logic [Wen_Width-1:0] bwen_q, bwen_d;
    logic [Add_Width-1:0] addr_q, addr_d;
    logic [Bits-1:0]      wdata_q, wdata_d;
    logic                 desc_valid_q, desc_valid_d;
    logic [Add_Width-1:0] desc_addr_q, desc_addr_d;
    logic [PtrW-1:0]      desc_len_q, desc_len_d;
    logic [KeepW-1:0]     desc_be_q, desc_be_d;

    logic                 accept, start_new, frame_word, abort, full, over, keep_word, drop, commit;
    logic [PtrW-1:0]      wptr, new_len, used;
    logic [Wen_Width-1:0] eop_bwen;

    sram_bwen_expand #(
        .KeepWidth(KeepW)
    ) u_bwen_expand (
        .keep_i(iKeep),
        .bwen_o(eop_bwen)
    );

    // A sop restarts the frame at the committed pointer, whether from IDLE or aborting WRITE.
    assign accept     = iValid & ready_q;
    assign start_new  = accept & iSop & ((state_q == StIdle) | (state_q == StWrite));
    assign frame_word = start_new | (accept & (state_q == StWrite));
    assign abort      = start_new & (state_q == StWrite);
    assign wptr       = start_new ? wr_ptr_q : cur_ptr_q;
    assign new_len    = start_new ? PtrW'(1) : len_q + PtrW'(1);
    assign used       = wptr - iRdPtr;
    assign full       = used[Add_Width];
    assign over       = new_len > PtrW'(MAX_WORDS);
    assign keep_word  = frame_word & ~full & ~over;
    assign drop       = frame_word & (full | over);
    assign commit     = keep_word & iEop;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= StIdle;
            ready_q      <= 1'b0;
            cur_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            len_q        <= '0;
            cen_q        <= 1'b1;
            wen_q        <= 1'b1;
            bwen_q       <= '1;
            addr_q       <= '0;
            wdata_q      <= '0;
            desc_valid_q <= 1'b0;
            desc_addr_q  <= '0;
            desc_len_q   <= '0;
            desc_be_q    <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            cur_ptr_q    <= cur_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            len_q        <= len_d;
            cen_q        <= cen_d;
            wen_q        <= wen_d;
            bwen_q       <= bwen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            desc_valid_q <= desc_valid_d;
            desc_addr_q  <= desc_addr_d;
            desc_len_q   <= desc_len_d;
            desc_be_q    <= desc_be_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StWrite: begin
                if (drop) begin
                    state_d = iEop ? StIdle : StDrop;
                end else if (commit) begin
                    state_d = StDesc;
                end else if (keep_word) begin
                    state_d = StWrite;
                end
            end
            StDrop: if (accept && iEop) state_d = StIdle;
            StDesc: if (iDescReady) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_d      = (state_d != StDesc);
        cur_ptr_d    = cur_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        len_d        = len_q;
        cen_d        = 1'b1;
        wen_d        = 1'b1;
        bwen_d       = '1;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        desc_valid_d = desc_valid_q & ~iDescReady;
        desc_addr_d  = desc_addr_q;
        desc_len_d   = desc_len_q;
        desc_be_d    = desc_be_q;
        if (drop) begin
            cur_ptr_d = wr_ptr_q;
            len_d     = '0;
        end else if (keep_word) begin
            cen_d     = 1'b0;
            wen_d     = 1'b0;
            addr_d    = wptr[Add_Width-1:0];
            wdata_d   = iData;
            bwen_d    = iEop ? eop_bwen : '0;
            cur_ptr_d = wptr + PtrW'(1);
            len_d     = new_len;
            if (iEop) begin
                wr_ptr_d     = wptr + PtrW'(1);
                desc_valid_d = 1'b1;
                desc_addr_d  = wr_ptr_q[Add_Width-1:0];
                desc_len_d   = new_len;
                desc_be_d    = iKeep;
            end
        end
    end

    always_comb begin
        oReady      = ready_q;
        oCEnA       = cen_q;
        oWEnA       = wen_q;
        oBWEnA      = bwen_q;
        oAddrA      = addr_q;
        oWDataA     = wdata_q;
        oWrPtr      = wr_ptr_q;
        oDescValid  = desc_valid_q;
        oDescAddr   = desc_addr_q;
        oDescLen    = desc_len_q;
        oDescLastBe = desc_be_q;
    end

`ifdef PKT_WR_STATS_EN
    logic [31:0] frm_cnt_q, frm_cnt_d, drop_cnt_q, drop_cnt_d;

    assign frm_cnt_d  = (commit && frm_cnt_q != '1) ? frm_cnt_q + 32'd1 : frm_cnt_q;
    assign drop_cnt_d = ((drop || abort) && drop_cnt_q != '1) ? drop_cnt_q + 32'd1 : drop_cnt_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            frm_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            frm_cnt_q  <= frm_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign oFrmCnt  = frm_cnt_q;
    assign oDropCnt = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = abort;
`endif

endmodule

// File: tb/tb_sram_pkt_writer.sv
// Directed self-checking bench for sram_pkt_writer: commit, backpressure, abort, reset, wrap,
// full and over-length drops.
module tb_sram_pkt_writer;

    logic        clk;
    logic        iRst, iValid, iSop, iEop, iDescReady;
    logic [3:0]  iKeep;
    logic [31:0] iData;
    logic [14:0] iRdPtr;
    logic        oReady, oCEnA, oWEnA, oDescValid;
    logic [31:0] oBWEnA, oWDataA;
    logic [13:0] oAddrA, oDescAddr;
    logic [14:0] oWrPtr, oDescLen;
    logic [3:0]  oDescLastBe;
`ifdef PKT_WR_STATS_EN
    logic [31:0] oFrmCnt, oDropCnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] wr_bwen_log[$];

    sram_pkt_writer dut (
        .iClk       (clk),
        .iRst       (iRst),
        .iValid     (iValid),
        .oReady     (oReady),
        .iSop       (iSop),
        .iEop       (iEop),
        .iKeep      (iKeep),
        .iData      (iData),
        .oCEnA      (oCEnA),
        .oWEnA      (oWEnA),
        .oBWEnA     (oBWEnA),
        .oAddrA     (oAddrA),
        .oWDataA    (oWDataA),
        .iRdPtr     (iRdPtr),
        .oWrPtr     (oWrPtr),
        .oDescValid (oDescValid),
        .iDescReady (iDescReady),
        .oDescAddr  (oDescAddr),
        .oDescLen   (oDescLen),
        .oDescLastBe(oDescLastBe)
`ifdef PKT_WR_STATS_EN
        ,
        .oFrmCnt    (oFrmCnt),
        .oDropCnt   (oDropCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!oCEnA && !oWEnA) begin
            wr_addr_log.push_back(oAddrA);
            wr_data_log.push_back(oWDataA);
            wr_bwen_log.push_back(oBWEnA);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_bwen_log.delete();
    endtask

    task automatic put_word(input logic sop, input logic eop, input logic [3:0] keep,
                            input logic [31:0] data);
        logic acc;
        int   budget;
        iValid = 1'b1; iSop = sop; iEop = eop; iKeep = keep; iData = data;
        acc = 1'b0;
        budget = 50;
        while (!acc && budget > 0) begin
            acc = oReady;
            tick();
            budget--;
        end
        if (!acc) begin
            n_fail++;
            $display("FAIL put_word_ready: oReady stayed 0 for 50 cycles, required 1");
        end
        iValid = 1'b0; iSop = 1'b0; iEop = 1'b0; iKeep = 4'hF;
    endtask

    task automatic send_frame(input int n, input logic [3:0] keep, input logic [31:0] base,
                              input bit with_eop);
        for (int i = 0; i < n; i++) begin
            put_word(i == 0, with_eop && (i == n - 1), (i == n - 1) ? keep : 4'hF, base + i);
        end
        tick();
        tick();
    endtask

    // Waits (bounded) for a descriptor, captures it, then acknowledges after hold cycles.
    task automatic take_desc(input int hold, output bit got, output logic [13:0] a,
                             output logic [14:0] len, output logic [3:0] be);
        int budget = 20;
        got = 1'b0;
        while (!oDescValid && budget > 0) begin
            tick();
            budget--;
        end
        got = oDescValid;
        a = oDescAddr; len = oDescLen; be = oDescLastBe;
        if (got) begin
            repeat (hold) tick();
            iDescReady = 1'b1;
            tick();
            iDescReady = 1'b0;
        end
    endtask

    task automatic fill(input int words);
        int left = words;
        int n;
        iDescReady = 1'b1;
        while (left > 0) begin
            n = (left > 388) ? 388 : left;
            send_frame(n, 4'hF, 32'h0, 1'b1);
            left -= n;
        end
        iDescReady = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        repeat (2) tick();
        iRst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (2) tick();
        n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", oReady); end
        n_checks++; if (oCEnA !== 1'b1) begin n_fail++; $display("FAIL rst_cen: got %b want 1", oCEnA); end
        n_checks++; if (oWEnA !== 1'b1) begin n_fail++; $display("FAIL rst_wen: got %b want 1", oWEnA); end
        n_checks++; if (oBWEnA !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_bwen: got %h want ffffffff", oBWEnA); end
        n_checks++; if (oAddrA !== 14'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", oAddrA); end
        n_checks++; if (oWDataA !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", oWDataA); end
        n_checks++; if (oWrPtr !== 15'd0) begin n_fail++; $display("FAIL rst_wrptr: got %h want 0", oWrPtr); end
        n_checks++; if (oDescValid !== 1'b0) begin n_fail++; $display("FAIL rst_dvalid: got %b want 0", oDescValid); end
        n_checks++; if ({oDescAddr, oDescLen, oDescLastBe} !== 33'd0) begin
            n_fail++; $display("FAIL rst_desc: got %h/%h/%h want 0/0/0", oDescAddr, oDescLen, oDescLastBe);
        end
        iRst = 1'b0;
        tick();
        n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", oReady); end
    endtask

    task automatic test_single_frame();
        bit got; logic [13:0] a; logic [14:0] len; logic [3:0] be;
        logic [31:0] eb [4];
        eb = '{32'h0, 32'h0, 32'h0, 32'hFF00_0000};
        clear_log();
        send_frame(4, 4'b0111, 32'hA000_0000, 1'b1);
        n_checks++; if (wr_addr_log.size() !== 4) begin n_fail++; $display("FAIL single_nwr: got %0d want 4", wr_addr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (wr_addr_log[i] !== 14'(i)) begin n_fail++; $display("FAIL single_addr%0d: got %h want %h", i, wr_addr_log[i], i); end
            n_checks++; if (wr_data_log[i] !== 32'hA000_0000 + i) begin n_fail++; $display("FAIL single_data%0d: got %h want %h", i, wr_data_log[i], 32'hA000_0000 + i); end
            n_checks++; if (wr_bwen_log[i] !== eb[i]) begin n_fail++; $display("FAIL single_bwen%0d: got %h want %h", i, wr_bwen_log[i], eb[i]); end
        end
        take_desc(0, got, a, len, be);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_desc_seen: got %b want 1", got); end
        n_checks++; if ({a, len, be} !== {14'd0, 15'd4, 4'b0111}) begin n_fail++; $display("FAIL single_desc: got %h/%h/%b want 0/4/0111", a, len, be); end
        n_checks++; if (oWrPtr !== 15'd4) begin n_fail++; $display("FAIL single_wrptr: got %h want 4", oWrPtr); end
        // One-word frame: sop and eop on the same beat.
        clear_log();
        send_frame(1, 4'b0001, 32'h0000_0055, 1'b1);
        n_checks++; if (wr_addr_log.size() !== 1) begin n_fail++; $display("FAIL one_nwr: got %0d want 1", wr_addr_log.size()); end
        n_checks++; if (wr_addr_log[0] !== 14'd4) begin n_fail++; $display("FAIL one_addr: got %h want 4", wr_addr_log[0]); end
        n_checks++; if (wr_bwen_log[0] !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL one_bwen: got %h want ffffff00", wr_bwen_log[0]); end
        take_desc(0, got, a, len, be);
        n_checks++; if ({got, a, len, be} !== {1'b1, 14'd4, 15'd1, 4'b0001}) begin n_fail++; $display("FAIL one_desc: got %b %h/%h/%b want 1 4/1/0001", got, a, len, be); end
        n_checks++; if (oWrPtr !== 15'd5) begin n_fail++; $display("FAIL one_wrptr: got %h want 5", oWrPtr); end
`ifdef PKT_WR_STATS_EN
        n_checks++; if (oFrmCnt !== 32'd2) begin n_fail++; $display("FAIL frm_cnt: got %0d want 2", oFrmCnt); end
`endif
    endtask

    task automatic test_desc_backpressure();
        int budget = 20;
        send_frame(2, 4'b1111, 32'hB000_0000, 1'b1);
        while (!oDescValid && budget > 0) begin tick(); budget--; end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", i, oReady); end
            n_checks++; if ({oDescValid, oDescAddr, oDescLen} !== {1'b1, 14'd5, 15'd2}) begin
                n_fail++; $display("FAIL bp_desc%0d: got %b %h/%h want 1 5/2", i, oDescValid, oDescAddr, oDescLen);
            end
            tick();
        end
        iDescReady = 1'b1;
        tick();
        iDescReady = 1'b0;
        n_checks++; if (oDescValid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", oDescValid); end
        n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", oReady); end
        n_checks++; if (oWrPtr !== 15'd7) begin n_fail++; $display("FAIL bp_wrptr: got %h want 7", oWrPtr); end
    endtask

    task automatic test_abort_and_reset();
        bit got; logic [13:0] a; logic [14:0] len; logic [3:0] be;
        logic [13:0] ea [5];
        ea = '{14'd7, 14'd8, 14'd7, 14'd8, 14'd9};
        clear_log();
        put_word(1'b1, 1'b0, 4'hF, 32'hB0);
        put_word(1'b0, 1'b0, 4'hF, 32'hB1);
        put_word(1'b1, 1'b0, 4'hF, 32'hC0);
        put_word(1'b0, 1'b0, 4'hF, 32'hC1);
        put_word(1'b0, 1'b1, 4'b0011, 32'hC2);
        tick(); tick();
        n_checks++; if (wr_addr_log.size() !== 5) begin n_fail++; $display("FAIL abort_nwr: got %0d want 5", wr_addr_log.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (wr_addr_log[i] !== ea[i]) begin n_fail++; $display("FAIL abort_addr%0d: got %h want %h", i, wr_addr_log[i], ea[i]); end
        end
        n_checks++; if (wr_bwen_log[4] !== 32'hFFFF_0000) begin n_fail++; $display("FAIL abort_bwen: got %h want ffff0000", wr_bwen_log[4]); end
        take_desc(0, got, a, len, be);
        n_checks++; if ({got, a, len, be} !== {1'b1, 14'd7, 15'd3, 4'b0011}) begin n_fail++; $display("FAIL abort_desc: got %b %h/%h/%b want 1 7/3/0011", got, a, len, be); end
        n_checks++; if (oWrPtr !== 15'd10) begin n_fail++; $display("FAIL abort_wrptr: got %h want a", oWrPtr); end
        // Reset with a partial frame in flight.
        send_frame(3, 4'hF, 32'hD0, 1'b0);
        do_reset();
        tick(); tick();
        n_checks++; if (oWrPtr !== 15'd0) begin n_fail++; $display("FAIL rstmid_wrptr: got %h want 0", oWrPtr); end
        n_checks++; if (oDescValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dvalid: got %b want 0", oDescValid); end
        clear_log();
        send_frame(2, 4'hF, 32'hE0, 1'b1);
        n_checks++; if (wr_addr_log[0] !== 14'd0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0", wr_addr_log[0]); end
        take_desc(0, got, a, len, be);
        n_checks++; if ({got, a, len} !== {1'b1, 14'd0, 15'd2}) begin n_fail++; $display("FAIL rstmid_desc: got %b %h/%h want 1 0/2", got, a, len); end
        n_checks++; if (oWrPtr !== 15'd2) begin n_fail++; $display("FAIL rstmid_wrptr2: got %h want 2", oWrPtr); end
    endtask

    task automatic test_wrap();
        bit got; logic [13:0] a; logic [14:0] len; logic [3:0] be;
        logic [13:0] ea [5];
        ea = '{14'd16382, 14'd16383, 14'd0, 14'd1, 14'd2};
        do_reset();
        iRdPtr = 15'd0;
        fill(16382);
        n_checks++; if (oWrPtr !== 15'd16382) begin n_fail++; $display("FAIL wrap_fill_wrptr: got %h want 3ffe", oWrPtr); end
        iRdPtr = 15'd16382;
        clear_log();
        send_frame(5, 4'hF, 32'hF000_0000, 1'b1);
        n_checks++; if (wr_addr_log.size() !== 5) begin n_fail++; $display("FAIL wrap_nwr: got %0d want 5", wr_addr_log.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (wr_addr_log[i] !== ea[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, wr_addr_log[i], ea[i]); end
        end
        take_desc(0, got, a, len, be);
        n_checks++; if ({got, a, len} !== {1'b1, 14'd16382, 15'd5}) begin n_fail++; $display("FAIL wrap_desc: got %b %h/%h want 1 3ffe/5", got, a, len); end
        n_checks++; if (oWrPtr !== 15'h4003) begin n_fail++; $display("FAIL wrap_wrptr: got %h want 4003", oWrPtr); end
    endtask

    task automatic test_full();
`ifdef PKT_WR_STATS_EN
        logic [31:0] drops0;
        drops0 = oDropCnt;
`endif
        // used = 0x4003 - 0x0003 = Word_Depth: buffer exactly full.
        iRdPtr = 15'h0003;
        clear_log();
        send_frame(2, 4'hF, 32'h1100, 1'b1);
        tick();
        n_checks++; if (wr_addr_log.size() !== 0) begin n_fail++; $display("FAIL full_nwr: got %0d want 0", wr_addr_log.size()); end
        n_checks++; if (oWrPtr !== 15'h4003) begin n_fail++; $display("FAIL full_wrptr: got %h want 4003", oWrPtr); end
        n_checks++; if (oDescValid !== 1'b0) begin n_fail++; $display("FAIL full_dvalid: got %b want 0", oDescValid); end
`ifdef PKT_WR_STATS_EN
        n_checks++; if (oDropCnt !== drops0 + 32'd1) begin n_fail++; $display("FAIL full_dropcnt: got %0d want %0d", oDropCnt, drops0 + 1); end
`endif
        // One free slot: first word fits, the eop word overflows and the frame is dropped.
        iRdPtr = 15'h0004;
        clear_log();
        send_frame(2, 4'hF, 32'h2200, 1'b1);
        tick();
        n_checks++; if (wr_addr_log.size() !== 1) begin n_fail++; $display("FAIL edge_nwr: got %0d want 1", wr_addr_log.size()); end
        n_checks++; if (wr_addr_log[0] !== 14'd3) begin n_fail++; $display("FAIL edge_addr: got %h want 3", wr_addr_log[0]); end
        n_checks++; if (oWrPtr !== 15'h4003) begin n_fail++; $display("FAIL edge_wrptr: got %h want 4003", oWrPtr); end
        n_checks++; if (oDescValid !== 1'b0) begin n_fail++; $display("FAIL edge_dvalid: got %b want 0", oDescValid); end
        n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL edge_ready: got %b want 1", oReady); end
    endtask

    task automatic test_max_len();
        bit got; logic [13:0] a; logic [14:0] len; logic [3:0] be;
        iRdPtr = 15'h4003;
        clear_log();
        send_frame(389, 4'hF, 32'h3000_0000, 1'b1);
        n_checks++; if (wr_addr_log.size() !== 388) begin n_fail++; $display("FAIL ovl389_nwr: got %0d want 388", wr_addr_log.size()); end
        n_checks++; if (oWrPtr !== 15'h4003) begin n_fail++; $display("FAIL ovl389_wrptr: got %h want 4003", oWrPtr); end
        n_checks++; if (oDescValid !== 1'b0) begin n_fail++; $display("FAIL ovl389_dvalid: got %b want 0", oDescValid); end
        clear_log();
        send_frame(390, 4'hF, 32'h4000_0000, 1'b1);
        n_checks++; if (wr_addr_log.size() !== 388) begin n_fail++; $display("FAIL ovl390_nwr: got %0d want 388", wr_addr_log.size()); end
        n_checks++; if (oDescValid !== 1'b0) begin n_fail++; $display("FAIL ovl390_dvalid: got %b want 0", oDescValid); end
        n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL ovl390_ready: got %b want 1", oReady); end
        clear_log();
        send_frame(388, 4'b0001, 32'h5000_0000, 1'b1);
        n_checks++; if (wr_addr_log[0] !== 14'd3) begin n_fail++; $display("FAIL max_first_addr: got %h want 3", wr_addr_log[0]); end
        take_desc(0, got, a, len, be);
        n_checks++; if ({got, a, len, be} !== {1'b1, 14'd3, 15'd388, 4'b0001}) begin n_fail++; $display("FAIL max_desc: got %b %h/%0d/%b want 1 3/388/0001", got, a, len, be); end
        n_checks++; if (oWrPtr !== 15'h4187) begin n_fail++; $display("FAIL max_wrptr: got %h want 4187", oWrPtr); end
    endtask

    initial begin
        iRst = 1'b1; iValid = 1'b0; iSop = 1'b0; iEop = 1'b0; iKeep = 4'hF; iData = 32'd0;
        iRdPtr = 15'd0; iDescReady = 1'b0;
        test_reset();
        test_single_frame();
        test_desc_backpressure();
        test_abort_and_reset();
        test_wrap();
        test_full();
        test_max_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
